mossbauer_gate_sequencer: RTL and testbench

Synchronous controller that sequences the two Mössbauer coincidence gate windows from the digitized drive level. It detects threshold crossings of the drive ramp (upward through LT opens channel 1, downward through HT opens channel 2) and enforces one-window-at-a-time with a fixed timeout. It counts RF2 detector pulses inside each window and reports per-window and accumulated totals. It sits between the drive-level sampler and the spectrum accumulation logic.

---
 rtl/mossbauer_gate_sequencer_if.sv | 33 +++
 rtl/mossbauer_gate_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_mossbauer_gate_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mossbauer_gate_sequencer_if.sv
// Mossbauer gate sequencer bus: drive-level/detector inputs and gate/count outputs.
interface mossbauer_gate_sequencer_if #(
    parameter int DW = 8,
    parameter int CW = 16
);
    logic          enable;
    logic          clear;
    logic [DW-1:0] drive;
    logic          drive_valid;
    logic          rf2;
    logic          gate1;
    logic          gate2;
    logic          c1;
    logic          c2;
    logic          win_done;
    logic          win_ch;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic [1:0]    state;

    // Sampler / test side: supplies drive samples and detector pulses.
    modport master (
        output enable, clear, drive, drive_valid, rf2,
        input  gate1, gate2, c1, c2, win_done, win_ch, win_cnt, cnt1, cnt2, state
    );

    // Sequencer side.
    modport slave (
        input  enable, clear, drive, drive_valid, rf2,
        output gate1, gate2, c1, c2, win_done, win_ch, win_cnt, cnt1, cnt2, state
    );
endinterface

// File: rtl/mossbauer_gate_sequencer.sv
// Mossbauer gate sequencer: opens one coincidence window at a time from drive
// ramp threshold crossings (up through LT -> ch1, down through HT -> ch2),
// enforces a fixed window timeout and counts synchronized rf2 edges per window.
module mossbauer_gate_sequencer #(
    parameter int DW          = 8,
    parameter int LT          = 30,
    parameter int HT          = 60,
    parameter int RESET_COUNT = 20000,
    parameter int TW          = 15,
    parameter int CW          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mossbauer_gate_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_OPEN1 = 2'd2,
        ST_OPEN2 = 2'd3
    } state_t;

    localparam logic [DW-1:0] LT_C   = DW'(LT);
    localparam logic [DW-1:0] HT_C   = DW'(HT);
    localparam logic [TW-1:0] T_LAST = TW'(RESET_COUNT - 1);
    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};

    // Saturating increment shared by the window and accumulated counters.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == C_MAX) begin
            r = v;
        end else begin
            r = v + C_ONE;
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          gl_q, gl_d;
    logic          lh_q, lh_d;
    logic          rf2_meta_q, rf2_sync_q, rf2_prev_q;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;
    logic          gate1_q, gate1_d;
    logic          gate2_q, gate2_d;
    logic          c1_q, c1_d;
    logic          c2_q, c2_d;
    logic          win_done_q, win_done_d;
    logic          win_ch_q, win_ch_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;

    logic          gl_s, lh_s, evt1_s, evt2_s;
    logic          timeout_s, open_s, rf2_edge_s, cnt_edge_s;
    logic          close_s, entry_s;
    logic [CW-1:0] wcnt_inc_s;

    assign gl_s       = (bus.drive > LT_C);
    assign lh_s       = (bus.drive < HT_C);
    assign evt1_s     = bus.drive_valid & ~gl_q & gl_s;
    assign evt2_s     = bus.drive_valid & ~lh_q & lh_s;
    assign timeout_s  = (timer_q == T_LAST);
    assign open_s     = (state_q == ST_OPEN1) || (state_q == ST_OPEN2);
    assign rf2_edge_s = rf2_sync_q & ~rf2_prev_q;
    assign cnt_edge_s = rf2_edge_s & open_s;

    // Two-flop synchronizer plus delay stage for rf2 rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf2_meta_q <= 1'b0;
            rf2_sync_q <= 1'b0;
            rf2_prev_q <= 1'b0;
        end else begin
            rf2_meta_q <= bus.rf2;
            rf2_sync_q <= rf2_meta_q;
            rf2_prev_q <= rf2_sync_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: disable dominates, then preemption, then window close.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (evt1_s) begin
                    state_d = ST_OPEN1;
                end else if (evt2_s) begin
                    state_d = ST_OPEN2;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_OPEN1: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (evt2_s) begin
                    state_d = ST_OPEN2;
                end else if (timeout_s || (bus.drive_valid && !gl_s)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_OPEN1;
                end
            end
            ST_OPEN2: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (evt1_s) begin
                    state_d = ST_OPEN1;
                end else if (timeout_s || (bus.drive_valid && !lh_s)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_OPEN2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: timer, counters, gates and window report.
    always_comb begin
        close_s    = open_s && (state_d != state_q);
        entry_s    = ((state_d == ST_OPEN1) || (state_d == ST_OPEN2)) && (state_d != state_q);
        wcnt_inc_s = cnt_edge_s ? sat_inc(wcnt_q) : wcnt_q;

        if (bus.drive_valid) begin
            gl_d = gl_s;
            lh_d = lh_s;
        end else begin
            gl_d = gl_q;
            lh_d = lh_q;
        end

        if (entry_s) begin
            timer_d = T_ZERO;
        end else if ((state_d == ST_OPEN1) || (state_d == ST_OPEN2)) begin
            timer_d = timer_q + T_ONE;
        end else begin
            timer_d = T_ZERO;
        end

        if (entry_s) begin
            wcnt_d = C_ZERO;
        end else if (open_s) begin
            wcnt_d = wcnt_inc_s;
        end else begin
            wcnt_d = wcnt_q;
        end

        if (bus.clear) begin
            cnt1_d = C_ZERO;
        end else if (cnt_edge_s && (state_q == ST_OPEN1)) begin
            cnt1_d = sat_inc(cnt1_q);
        end else begin
            cnt1_d = cnt1_q;
        end

        if (bus.clear) begin
            cnt2_d = C_ZERO;
        end else if (cnt_edge_s && (state_q == ST_OPEN2)) begin
            cnt2_d = sat_inc(cnt2_q);
        end else begin
            cnt2_d = cnt2_q;
        end

        gate1_d    = (state_d == ST_OPEN1);
        gate2_d    = (state_d == ST_OPEN2);
        c1_d       = gate1_q & rf2_sync_q;
        c2_d       = gate2_q & rf2_sync_q;
        win_done_d = close_s;

        if (close_s) begin
            win_ch_d  = (state_q == ST_OPEN2);
            win_cnt_d = wcnt_inc_s;
        end else begin
            win_ch_d  = win_ch_q;
            win_cnt_d = win_cnt_q;
        end
    end

    // Datapath and output registers; comparator history resets to "above LT, not below HT".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= T_ZERO;
            gl_q       <= 1'b1;
            lh_q       <= 1'b0;
            wcnt_q     <= C_ZERO;
            cnt1_q     <= C_ZERO;
            cnt2_q     <= C_ZERO;
            gate1_q    <= 1'b0;
            gate2_q    <= 1'b0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            win_done_q <= 1'b0;
            win_ch_q   <= 1'b0;
            win_cnt_q  <= C_ZERO;
        end else begin
            timer_q    <= timer_d;
            gl_q       <= gl_d;
            lh_q       <= lh_d;
            wcnt_q     <= wcnt_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            gate1_q    <= gate1_d;
            gate2_q    <= gate2_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            win_done_q <= win_done_d;
            win_ch_q   <= win_ch_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

    assign bus.gate1    = gate1_q;
    assign bus.gate2    = gate2_q;
    assign bus.c1       = c1_q;
    assign bus.c2       = c2_q;
    assign bus.win_done = win_done_q;
    assign bus.win_ch   = win_ch_q;
    assign bus.win_cnt  = win_cnt_q;
    assign bus.cnt1     = cnt1_q;
    assign bus.cnt2     = cnt2_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mossbauer_gate_sequencer.sv
// Testbench for mossbauer_gate_sequencer: directed scenario plus randomized
// drive/rf2 traffic, every cycle compared against a behavioural model.
module tb_mossbauer_gate_sequencer;

    localparam int DW   = 8;
    localparam int LT   = 30;
    localparam int HT   = 60;
    localparam int RC   = 20000;
    localparam int TW   = 15;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    // 100 MHz clock.
    always #5 clk = ~clk;

    mossbauer_gate_sequencer_if #(.DW(DW), .CW(CW)) bus ();

    mossbauer_gate_sequencer #(
        .DW(DW), .LT(LT), .HT(HT), .RESET_COUNT(RC), .TW(TW), .CW(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle, 1 armed, 2 window ch1, 3 window ch2.
    int m_mode, m_age, m_wcnt, m_cnt1, m_cnt2;
    bit m_above, m_below;
    bit m_h1, m_h2, m_h3;
    bit e_c1, e_c2, e_done, e_ch;
    int e_wcnt;
    int c1_rises;
    bit c1_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_wcnt = 0; m_cnt1 = 0; m_cnt2 = 0;
        m_above = 1'b1; m_below = 1'b0;
        m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
        e_c1 = 1'b0; e_c2 = 1'b0; e_done = 1'b0; e_ch = 1'b0; e_wcnt = 0;
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        bit dv, en, up, down, lvl, edg, counted, shut;
        int d, nm, wc;
        dv  = bus.drive_valid;
        en  = bus.enable;
        d   = int'(bus.drive);
        lvl = m_h2;
        edg = m_h2 && !m_h3;
        up   = dv && !m_above && (d > LT);
        down = dv && !m_below && (d < HT);
        counted = edg && (m_mode >= 2);
        wc = (counted && m_wcnt < CMAX) ? m_wcnt + 1 : m_wcnt;
        e_c1 = (m_mode == 2) && lvl;
        e_c2 = (m_mode == 3) && lvl;
        if (counted && m_mode == 2 && m_cnt1 < CMAX) m_cnt1++;
        if (counted && m_mode == 3 && m_cnt2 < CMAX) m_cnt2++;
        if (bus.clear) begin
            m_cnt1 = 0;
            m_cnt2 = 0;
        end
        nm = m_mode;
        if (!en) nm = 0;
        else if (m_mode == 0) nm = 1;
        else if (m_mode == 1) begin
            if (up) nm = 2;
            else if (down) nm = 3;
        end else if (m_mode == 2) begin
            if (down) nm = 3;
            else if (m_age == RC - 1 || (dv && d <= LT)) nm = 1;
        end else begin
            if (up) nm = 2;
            else if (m_age == RC - 1 || (dv && d >= HT)) nm = 1;
        end
        shut = (m_mode >= 2) && (nm != m_mode);
        e_done = shut;
        if (shut) begin
            e_ch   = (m_mode == 3);
            e_wcnt = wc;
        end
        if (nm >= 2 && nm != m_mode) begin
            m_age  = 0;
            m_wcnt = 0;
        end else begin
            m_age  = m_age + 1;
            m_wcnt = wc;
        end
        if (dv) begin
            m_above = (d > LT);
            m_below = (d < HT);
        end
        m_h3 = m_h2;
        m_h2 = m_h1;
        m_h1 = bus.rf2;
        m_mode = nm;
    endtask

    task automatic check_all();
        chk("gate1", bus.gate1, (m_mode == 2));
        chk("gate2", bus.gate2, (m_mode == 3));
        chk("state", bus.state, m_mode);
        chk("cnt1", bus.cnt1, m_cnt1);
        chk("cnt2", bus.cnt2, m_cnt2);
        chk("c1", bus.c1, e_c1);
        chk("c2", bus.c2, e_c2);
        chk("win_done", bus.win_done, e_done);
        if (e_done) begin
            chk("win_ch", bus.win_ch, e_ch);
            chk("win_cnt", bus.win_cnt, e_wcnt);
        end
    endtask

    // One clock: model follows the DUT edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (bus.c1 === 1'b1 && !c1_prev) c1_rises++;
        c1_prev = (bus.c1 === 1'b1);
    endtask

    task automatic sample(input int d);
        bus.drive       = DW'(d);
        bus.drive_valid = 1'b1;
        cyc();
        bus.drive_valid = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.rf2 = 1'b1;
        repeat (hi) cyc();
        bus.rf2 = 1'b0;
        repeat (lo) cyc();
    endtask

    int vals[12] = '{0, 20, 29, 30, 31, 45, 59, 60, 61, 100, 200, 255};

    initial begin
        int run;
        int guard;
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.clear = 1'b0; bus.drive = '0;
        bus.drive_valid = 1'b0; bus.rf2 = 1'b0;
        c1_rises = 0; c1_prev = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_state", bus.state, 0);
        chk("rst_gate1", bus.gate1, 0);
        chk("rst_gate2", bus.gate2, 0);
        chk("rst_done", bus.win_done, 0);
        chk("rst_wcnt", bus.win_cnt, 0);
        chk("rst_cnt1", bus.cnt1, 0);
        rst_n = 1'b1;

        // Window 1 by upward LT crossing, runs to timeout.
        bus.enable = 1'b1;
        cyc();
        chk("armed", bus.state, 1);
        sample(20);
        chk("no_open_on_20", bus.gate1, 0);
        sample(40);
        chk("open1", bus.gate1, 1);
        run = 1;
        guard = 0;
        while (bus.gate1 === 1'b1 && guard < RC + 100) begin
            cyc();
            if (bus.gate1 === 1'b1) run++;
            guard++;
        end
        chk("timeout_len", run, RC);
        chk("timeout_done", bus.win_done, 1);
        chk("timeout_wcnt", bus.win_cnt, 0);
        chk("timeout_state", bus.state, 1);

        // Window with five rf2 pulses.
        sample(20);
        sample(40);
        c1_rises = 0;
        repeat (5) pulse(3, 3);
        repeat (4) cyc();
        chk("c1_rises", c1_rises, 5);
        chk("cnt1_five", bus.cnt1, 5);
        chk("cnt2_zero", bus.cnt2, 0);

        // Preempt ch1 -> ch2, then ch2 -> ch1, then close on low sample.
        sample(70);
        sample(50);
        chk("pre12_gate2", bus.gate2, 1);
        chk("pre12_gate1", bus.gate1, 0);
        chk("pre12_done", bus.win_done, 1);
        chk("pre12_ch", bus.win_ch, 0);
        chk("pre12_cnt", bus.win_cnt, 5);
        sample(20);
        chk("ch2_holds", bus.gate2, 1);
        sample(40);
        chk("pre21_gate1", bus.gate1, 1);
        chk("pre21_ch", bus.win_ch, 1);
        sample(25);
        chk("close_low", bus.state, 1);
        chk("close_done", bus.win_done, 1);

        // Saturation of cnt1, then clear against a simultaneous edge.
        sample(20);
        sample(40);
        repeat (20) pulse(2, 2);
        repeat (4) cyc();
        chk("cnt1_sat", bus.cnt1, CMAX);
        bus.rf2 = 1'b1;
        cyc();
        cyc();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        bus.rf2 = 1'b0;
        chk("clear_wins", bus.cnt1, 0);
        repeat (3) cyc();

        // Asynchronous reset in the middle of a ch2 window.
        sample(70);
        sample(50);
        chk("open2_again", bus.gate2, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gate2", bus.gate2, 0);
        chk("arst_state", bus.state, 0);
        chk("arst_done", bus.win_done, 0);
        chk("arst_cnt2", bus.cnt2, 0);
        model_reset();
        bus.enable = 1'b0;
        bus.drive = DW'(50);
        bus.drive_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        bus.drive_valid = 1'b0;
        bus.enable = 1'b1;
        cyc();
        cyc();
        chk("post_rst_armed", bus.state, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.drive = DW'(vals[$urandom_range(0, 11)]);
            bus.drive_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus.rf2 = ~bus.rf2;
            bus.enable = ($urandom_range(0, 299) != 0);
            bus.clear  = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
